// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-aligned reads to instruction memory,
// buffers up to DEPTH {pc, instr} pairs and hands them to the control unit.
// A redirect flushes the queue and restarts fetching at a new address. A read
// that is still in flight when the redirect arrives is finished and discarded.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FQredirect,
  input  logic [31:0] FQredirect_pc,
  output logic        FQmem_req,
  output logic [31:0] FQmem_addr,
  input  logic        FQmem_ack,
  input  logic [31:0] FQmem_rdata,
  output logic        FQvalid,
  output logic [31:0] FQinstr,
  output logic [31:0] FQpc,
  input  logic        FQready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] count_after_push;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign FQvalid = (count_q != '0);
  assign pop     = FQvalid && FQready;
  // Occupancy if the fetch in flight is pushed this cycle (pop still honoured).
  assign count_after_push = count_q + CW'(1) - CW'(pop);

  // Head of queue comes from the storage registers; an empty queue shows zeros.
  assign FQinstr = FQvalid ? instr_mem_q[rd_ptr_q] : '0;
  assign FQpc    = FQvalid ? pc_mem_q[rd_ptr_q]    : '0;

  // Fetch FSM: request issue, push decision and redirect handling.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    FQmem_req   = 1'b0;
    FQmem_addr  = align_pc(fetch_pc_q);
    case (state_q)
      S_IDLE: begin
        if (FQredirect) begin
          fetch_pc_d = align_pc(FQredirect_pc);
          state_d    = S_REQ;
        end else if (count_q < FULL) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        FQmem_req = 1'b1;
        if (FQredirect) begin
          fetch_pc_d = align_pc(FQredirect_pc);
          // An un-acked read must still complete; remember its address so the
          // bus stays stable while we wait to throw its data away.
          if (!FQmem_ack) begin
            drop_addr_d = align_pc(fetch_pc_q);
            state_d     = S_DROP;
          end
        end else if (FQmem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_after_push < FULL) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        FQmem_req  = 1'b1;
        FQmem_addr = drop_addr_q;
        if (FQredirect) begin
          fetch_pc_d = align_pc(FQredirect_pc);
        end
        if (FQmem_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue pointers and occupancy; a redirect empties the queue outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (FQredirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= align_pc(RESET_PC);
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Data storage: written only on a push outside reset, never cleared.
  always_ff @(posedge clk) begin
    drop_addr_q <= drop_addr_d;
    if (reset && push) begin
      pc_mem_q[wr_ptr_q]    <= align_pc(fetch_pc_q);
      instr_mem_q[wr_ptr_q] <= FQmem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with two scoreboards: memory-side (addresses
// of every acknowledged read) and consumer-side (every popped {pc, instr}).
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        FQredirect;
  logic [31:0] FQredirect_pc;
  logic        FQmem_req;
  logic [31:0] FQmem_addr;
  logic        FQmem_ack;
  logic [31:0] FQmem_rdata;
  logic        FQvalid;
  logic [31:0] FQinstr;
  logic [31:0] FQpc;
  logic        FQready;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int ack_req_total = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .FQredirect   (FQredirect),
    .FQredirect_pc(FQredirect_pc),
    .FQmem_req    (FQmem_req),
    .FQmem_addr   (FQmem_addr),
    .FQmem_ack    (FQmem_ack),
    .FQmem_rdata  (FQmem_rdata),
    .FQvalid      (FQvalid),
    .FQinstr      (FQinstr),
    .FQpc         (FQpc),
    .FQready      (FQready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word is its address XOR a fixed pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: acknowledges while granted acks remain; checks each address.
  initial begin
    FQmem_ack   = 1'b0;
    FQmem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #3;
      if (FQmem_req && ack_cnt < ack_req_total) begin
        FQmem_ack   = 1'b1;
        FQmem_rdata = mem_word(FQmem_addr);
        ack_cnt++;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got %h expected none", FQmem_addr);
        end else begin
          check32("ack_addr", FQmem_addr, exp_addr.pop_front());
        end
      end else begin
        FQmem_ack   = 1'b0;
        FQmem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // Consumer monitor: every honoured pop must match the next expected entry.
  always @(negedge clk) begin
    if (reset && FQvalid && FQready && !FQredirect) begin
      if (exp_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected none", FQpc);
      end else begin
        logic [31:0] e;
        e = exp_data.pop_front();
        check32("pop_pc", FQpc, e);
        check32("pop_instr", FQinstr, mem_word(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Grant n acks and wait for them; cyc returns the extra cycles consumed.
  task automatic do_acks(input int n, output int cyc);
    int tgt;
    tgt = ack_cnt + n;
    ack_req_total = tgt;
    cyc = 0;
    #2;
    while (ack_cnt < tgt && cyc < 100) begin
      @(posedge clk);
      #4;
      cyc++;
    end
    check32("acks_done", ack_cnt, tgt);
    ack_req_total = ack_cnt;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && exp_data.size() != 0; c++) tick();
    check32("drain", exp_data.size(), 0);
    check32("drain_valid", {31'b0, FQvalid}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int base;
    reset = 1'b0;
    FQredirect = 1'b0;
    FQredirect_pc = 32'h0;
    FQready = 1'b0;

    // Reset state
    repeat (3) tick();
    check32("rst_valid", {31'b0, FQvalid}, 32'd0);
    check32("rst_req", {31'b0, FQmem_req}, 32'd0);
    check32("rst_instr", FQinstr, 32'd0);
    check32("rst_pc", FQpc, 32'd0);
    reset = 1'b1;
    tick();
    check32("first_req", {31'b0, FQmem_req}, 32'd1);
    check32("first_addr", FQmem_addr, 32'h0);

    // Fill with consumer stalled: exactly four pushes, then request drops
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(32'(i * 4));
      exp_data.push_back(32'(i * 4));
    end
    base = ack_cnt;
    ack_req_total = ack_cnt + 8;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        check32("latency_valid", {31'b0, FQvalid}, 32'd1);
        check32("latency_pc", FQpc, 32'h0);
      end
    end
    check32("full_pushes", ack_cnt - base, 32'd4);
    check32("full_req", {31'b0, FQmem_req}, 32'd0);
    check32("full_valid", {31'b0, FQvalid}, 32'd1);
    ack_req_total = ack_cnt;
    FQready = 1'b1;
    tick();
    FQready = 1'b0;
    tick();
    check32("refill_req", {31'b0, FQmem_req}, 32'd1);
    check32("refill_addr", FQmem_addr, 32'h10);

    // Streaming with zero-wait memory and an always-ready consumer
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(32'h10 + 32'(i * 4));
      exp_data.push_back(32'h10 + 32'(i * 4));
    end
    FQready = 1'b1;
    do_acks(8, cyc);
    check32("stream_rate", cyc, 32'd7);
    drain();
    check32("stream_next_addr", FQmem_addr, 32'h30);

    // Redirect (unaligned target) while the read to 0x30 is pending
    FQready = 1'b0;
    FQredirect = 1'b1;
    FQredirect_pc = 32'h0000_0103;
    tick();
    FQredirect = 1'b0;
    check32("drop_req", {31'b0, FQmem_req}, 32'd1);
    check32("drop_addr", FQmem_addr, 32'h30);
    repeat (2) tick();
    check32("drop_hold", FQmem_addr, 32'h30);
    exp_addr.push_back(32'h30);
    exp_addr.push_back(32'h100);
    do_acks(1, cyc);
    tick();
    check32("redir_addr", FQmem_addr, 32'h100);
    check32("redir_discard", {31'b0, FQvalid}, 32'd0);
    do_acks(1, cyc);
    tick();
    check32("redir_valid", {31'b0, FQvalid}, 32'd1);
    check32("redir_pc", FQpc, 32'h100);
    check32("redir_instr", FQinstr, mem_word(32'h100));

    // Redirect with same-cycle ack and pop at count=2
    exp_addr.push_back(32'h104);
    do_acks(1, cyc);
    tick();
    check32("two_head_pc", FQpc, 32'h100);
    exp_addr.push_back(32'h108);
    ack_req_total = ack_cnt + 1;
    FQredirect = 1'b1;
    FQredirect_pc = 32'h200;
    FQready = 1'b1;
    tick();
    FQredirect = 1'b0;
    check32("flush_valid", {31'b0, FQvalid}, 32'd0);
    check32("flush_req", {31'b0, FQmem_req}, 32'd1);
    check32("flush_addr", FQmem_addr, 32'h200);
    check32("flush_ack_used", ack_cnt, ack_req_total);

    // Redirect into DROP, redirect again while dropping, then wrap at 2^32
    FQredirect = 1'b1;
    FQredirect_pc = 32'h300;
    tick();
    FQredirect_pc = 32'hFFFF_FFFC;
    check32("drop2_addr", FQmem_addr, 32'h200);
    tick();
    FQredirect = 1'b0;
    check32("drop2_hold", FQmem_addr, 32'h200);
    exp_addr.push_back(32'h200);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_data.push_back(32'hFFFF_FFFC);
    exp_data.push_back(32'h0);
    exp_data.push_back(32'h4);
    do_acks(1, cyc);
    tick();
    check32("wrap_addr", FQmem_addr, 32'hFFFF_FFFC);
    do_acks(3, cyc);
    drain();
    check32("wrap_next_addr", FQmem_addr, 32'h8);

    // Reset with three entries queued and a read outstanding (acked this cycle)
    FQready = 1'b0;
    exp_addr.push_back(32'h8);
    exp_addr.push_back(32'hC);
    exp_addr.push_back(32'h10);
    do_acks(3, cyc);
    tick();
    check32("pre_rst_valid", {31'b0, FQvalid}, 32'd1);
    check32("pre_rst_pc", FQpc, 32'h8);
    exp_addr.push_back(32'h14);
    ack_req_total = ack_cnt + 1;
    reset = 1'b0;
    tick();
    check32("mid_rst_valid", {31'b0, FQvalid}, 32'd0);
    check32("mid_rst_req", {31'b0, FQmem_req}, 32'd0);
    check32("mid_rst_pc", FQpc, 32'h0);
    check32("mid_rst_instr", FQinstr, 32'h0);
    check32("mid_rst_ack_used", ack_cnt, ack_req_total);
    reset = 1'b1;
    tick();
    check32("restart_req", {31'b0, FQmem_req}, 32'd1);
    check32("restart_addr", FQmem_addr, 32'h0);
    exp_addr.push_back(32'h0);
    exp_data.push_back(32'h0);
    FQready = 1'b1;
    do_acks(1, cyc);
    drain();

    check32("sb_addr_empty", exp_addr.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
